// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        fetch_state_e state;
        logic         kill;
    } fetch_dbg_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, one buffered instruction,
// with branch redirects that can arrive while a request is still waiting.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        fetch_stall,
    output fetch_dbg_t  dbg
);

    localparam logic [31:0] STEP = 32'(INSTR_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_reg_q, pc_reg_d;
    logic [31:0]  redirect_q, redirect_d;
    logic         kill_q, kill_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  instr_q, instr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_reg_q   <= RESET_PC;
            redirect_q <= '0;
            kill_q     <= 1'b0;
            pc_out_q   <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_reg_q   <= pc_reg_d;
            redirect_q <= redirect_d;
            kill_q     <= kill_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_reg_d   = pc_reg_q;
        redirect_d = redirect_q;
        kill_d     = kill_q;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        unique case (state_q)
            ST_FETCH: begin
                if (branch_taken) begin
                    // The address bus must stay put until the memory answers, so an
                    // early redirect is parked and applied when the stale word returns.
                    if (imem_ready) begin
                        pc_reg_d = branch_addr;
                        kill_d   = 1'b0;
                    end else begin
                        redirect_d = branch_addr;
                        kill_d     = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (kill_q) begin
                        pc_reg_d = redirect_q;
                        kill_d   = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_reg_q + STEP;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_reg_d = branch_addr;
                    state_d  = ST_FETCH;
                end else if (!freeze) begin
                    pc_reg_d = pc_reg_q + STEP;
                    state_d  = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign fetch_stall = (state_q == ST_FETCH);
    assign imem_addr   = pc_reg_q;
    assign PC          = pc_out_q;
    assign Instruction = instr_q;
    assign dbg         = '{state: state_q, kill: kill_q};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: transaction-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        fetch_stall;
    fetch_dbg_t  dbg;

    int checks_total;
    int checks_passed;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .PC           (PC),
        .Instruction  (Instruction),
        .fetch_stall  (fetch_stall),
        .dbg          (dbg)
    );

    // Memory contents: word at address a is 0xA000_0000 | a/4 (so 0,4,8 -> A..0,A..1,A..2).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | (a >> 2);
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // ---------------- reference model ----------------
    // Thinks in terms of "a request is outstanding at addr" and "a redirect is pending".
    logic        m_valid;
    logic        m_outstanding;
    logic [31:0] m_addr;
    logic        m_redirect_pending;
    logic [31:0] m_redirect_target;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid            = 1'b1;
            m_outstanding      = 1'b1;
            m_addr             = 32'h0000_0000;
            m_redirect_pending = 1'b0;
            m_redirect_target  = '0;
            m_pc               = '0;
            m_instr            = '0;
        end else if (m_valid) begin
            if (m_outstanding) begin
                if (branch_taken && imem_ready) begin
                    m_addr = branch_addr;
                    m_redirect_pending = 1'b0;
                end else if (branch_taken) begin
                    m_redirect_target  = branch_addr;
                    m_redirect_pending = 1'b1;
                end else if (imem_ready && m_redirect_pending) begin
                    m_addr = m_redirect_target;
                    m_redirect_pending = 1'b0;
                end else if (imem_ready) begin
                    m_instr       = mem_word(m_addr);
                    m_pc          = m_addr + 32'd4;
                    m_outstanding = 1'b0;
                end
            end else if (branch_taken) begin
                m_addr        = branch_addr;
                m_outstanding = 1'b1;
            end else if (!freeze) begin
                m_addr        = m_addr + 32'd4;
                m_outstanding = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_imem_req",    32'(imem_req),    32'(m_outstanding));
            chk("cyc_fetch_stall", 32'(fetch_stall), 32'(m_outstanding));
            chk("cyc_imem_addr",   imem_addr,        m_addr);
            chk("cyc_pc",          PC,               m_pc);
            chk("cyc_instruction", Instruction,      m_instr);
            chk("cyc_kill",        32'(dbg.kill),    32'(m_redirect_pending));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic f, input logic b,
                        input logic [31:0] ba, input logic rdy);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_ready   = rdy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b0;

        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_addr",  imem_addr,       32'h0);
        chk("rst_pc",    PC,              32'h0);
        chk("rst_instr", Instruction,     32'h0);
        chk("rst_req",   32'(imem_req),   32'd1);

        // Zero-wait streaming: one instruction every two cycles
        step(0, 0, 0, 0, 1);
        chk("s0_pc",    PC,          32'd4);
        chk("s0_instr", Instruction, 32'hA000_0000);
        chk("s0_req",   32'(imem_req), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("s1_addr",  imem_addr,   32'd4);
        step(0, 0, 0, 0, 1);
        chk("s1_pc",    PC,          32'd8);
        chk("s1_instr", Instruction, 32'hA000_0001);
        step(0, 0, 0, 0, 1);
        chk("s2_addr",  imem_addr,   32'd8);
        step(0, 0, 0, 0, 1);
        chk("s2_pc",    PC,          32'd12);
        chk("s2_instr", Instruction, 32'hA000_0002);
        step(0, 0, 0, 0, 1);
        chk("s3_addr",  imem_addr,   32'd12);

        // Three wait states
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("wait_addr",  imem_addr,         32'd12);
            chk("wait_stall", 32'(fetch_stall),  32'd1);
        end
        step(0, 0, 0, 0, 1);
        chk("wait_pc",    PC,          32'd16);
        chk("wait_instr", Instruction, 32'hA000_0003);

        // Freeze holds the buffered instruction
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 1);
            chk("frz_pc",    PC,            32'd16);
            chk("frz_instr", Instruction,   32'hA000_0003);
            chk("frz_req",   32'(imem_req), 32'd0);
        end
        step(0, 0, 0, 0, 0);
        chk("frz_resume_addr", imem_addr,     32'd16);
        chk("frz_resume_req",  32'(imem_req), 32'd1);

        // Redirect to 0x8, then branch to 0x80 and 0x100 while 0x8 is waiting
        step(0, 0, 1, 32'h8, 1);
        chk("br_ready_addr", imem_addr, 32'h8);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h80, 0);
        chk("kill_set",      32'(dbg.kill), 32'd1);
        chk("kill_addr",     imem_addr,     32'h8);
        step(0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 0, 1);
        chk("kill_redirect", imem_addr,     32'h100);
        chk("kill_cleared",  32'(dbg.kill), 32'd0);
        chk("kill_no_stale", 32'(Instruction != mem_word(32'h8)), 32'd1);
        chk("kill_instr",    Instruction,   32'hA000_0003);
        step(0, 0, 0, 0, 1);
        chk("br_pc",    PC,          32'h104);
        chk("br_instr", Instruction, 32'hA000_0040);

        // Branch beats freeze in HOLD
        step(0, 1, 1, 32'h40, 0);
        chk("brfrz_req",  32'(imem_req), 32'd1);
        chk("brfrz_addr", imem_addr,     32'h40);

        // Reset while a redirect is pending
        step(0, 0, 1, 32'h300, 0);
        chk("pre_rst_kill", 32'(dbg.kill), 32'd1);
        step(1, 0, 0, 0, 0);
        chk("mid_rst_addr",  imem_addr,     32'h0);
        chk("mid_rst_pc",    PC,            32'h0);
        chk("mid_rst_instr", Instruction,   32'h0);
        chk("mid_rst_kill",  32'(dbg.kill), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("post_rst_pc",    PC,          32'd4);
        chk("post_rst_instr", Instruction, 32'hA000_0000);

        // Address wrap at the top of memory
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 1);
        chk("wrap_pc",    PC,          32'h0);
        chk("wrap_instr", Instruction, 32'hBFFF_FFFF);
        step(0, 0, 0, 0, 0);
        chk("wrap_addr",  imem_addr,   32'h0);

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
